// File: rtl/sigmoid_backward_stream.sv
// Sigmoid backward pass on a valid/ready stream: dx = g * y*(1-y), y clamped to [0,1]; optional rounding via SIGMOID_BWD_ROUND_EN.
// Latency: 3 register stages (clamp, s = y*(1-y), dx = g*s); one element per cycle when out_ready stays high.
// Backpressure: one global advance (!out_valid || out_ready) stalls every stage together; in_ready equals advance.
module sigmoid_backward_stream #(
  parameter int WIDTH_in_data     = 16,
  parameter int WIDTH_each_data_x = 17,
  parameter int WIDTH_each_data_y = 33
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_each_data_y-1:0] in_y,
  input  logic [WIDTH_each_data_x-1:0] in_g,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_each_data_x-1:0] out_dx,
  output logic                         out_last,
  output logic                         out_clip
);

  localparam int FRAME = WIDTH_in_data * WIDTH_in_data;
  localparam int CW    = $clog2(FRAME);
  localparam int WX    = WIDTH_each_data_x;
  localparam int WY    = WIDTH_each_data_y;
  // clamped y lives in [0, 2^28] so 29 unsigned bits are enough
  localparam int YW    = 29;
  // s = (yc*(2^28-yc)) >> 28 taken from a 57-bit product keeps 29 bits (value never exceeds 2^26)
  localparam int SW    = 29;
  // signed g times zero-extended s
  localparam int PW    = WX + SW + 1;
  localparam logic [YW-1:0] ONE = 29'h1000_0000;

  logic advance;
  logic accept;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // frame position of the next accepted element
  logic [CW-1:0] elem_cnt;
  logic          cnt_last;
  assign cnt_last = (elem_cnt == CW'(FRAME - 1));

  // S1 combinational clamp of the incoming activation
  logic          y_neg;
  logic          y_big;
  logic [YW-1:0] yc_next;
  assign y_neg   = in_y[WY-1];
  assign y_big   = $signed(in_y) > $signed({{(WY-YW){1'b0}}, ONE});
  assign yc_next = y_neg ? '0 : (y_big ? ONE : in_y[YW-1:0]);

  logic          s1_vld, s1_last, s1_clip;
  logic [YW-1:0] s1_yc;
  logic [WX-1:0] s1_g;

  logic          s2_vld, s2_last, s2_clip;
  logic [SW-1:0] s2_s;
  logic [WX-1:0] s2_g;

  // S2 full-precision unsigned product of yc and its complement
  logic [56:0] s2_prod;
  assign s2_prod = 57'(s1_yc) * 57'(ONE - s1_yc);

  // S3 full-precision signed product of gradient and slope
  logic signed [PW-1:0] s3_prod;
  logic signed [PW-1:0] s3_sum;
  assign s3_prod = PW'($signed(s2_g)) * PW'($signed({1'b0, s2_s}));
`ifdef SIGMOID_BWD_ROUND_EN
  // half an output LSB so the shift below rounds half up
  localparam logic signed [PW-1:0] RND = PW'(64'd134217728);
  assign s3_sum = s3_prod + RND;
`else
  assign s3_sum = s3_prod;
`endif

  // element counter: advances on each accepted input, wraps after the frame's last element
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= cnt_last ? '0 : elem_cnt + 1'b1;
    end
  end

  // stage 1: register the clamped activation, gradient and tags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_yc   <= '0;
      s1_g    <= '0;
      s1_last <= 1'b0;
      s1_clip <= 1'b0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_yc   <= yc_next;
      s1_g    <= in_g;
      s1_last <= cnt_last;
      s1_clip <= y_neg || y_big;
    end
  end

  // stage 2: register the sigmoid slope s = yc*(1-yc)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld  <= 1'b0;
      s2_s    <= '0;
      s2_g    <= '0;
      s2_last <= 1'b0;
      s2_clip <= 1'b0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_s    <= SW'(s2_prod >> 28);
      s2_g    <= s1_g;
      s2_last <= s1_last;
      s2_clip <= s1_clip;
    end
  end

  // stage 3: register dx = g*s scaled back to 14 fractional bits; held while downstream stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_dx    <= '0;
      out_last  <= 1'b0;
      out_clip  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_vld;
      out_dx    <= WX'(s3_sum >>> 28);
      out_last  <= s2_last;
      out_clip  <= s2_clip;
    end
  end

endmodule
